evt_trig_collision_resolver: RTL and testbench

//  N-slave LIN event-triggered frame responder with collision detection and resolution.
//  - Tracks per-slave "signal updated" flags.
//  - On an event-triggered header, publishes the wired-AND of all pending slaves' first response byte.
//  - On more than one responder: flags a collision, then serves each colliding slave in turn on

---
 rtl/lin_pkg.sv | 16 +
 rtl/lin_prio_enc.sv | 23 ++
 rtl/evt_trig_collision_resolver.sv | 139 +++++++++++++
 tb/tb_evt_trig_collision_resolver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lin_pkg.sv
// Shared LIN definitions: framed byte width, idle bus value, resolver state encoding
// and the unconditional-frame PIDs carried by slave responses.
package lin_pkg;

    localparam int LIN_BYTE_W = 10;
    localparam logic [LIN_BYTE_W-1:0] LIN_RECESSIVE = {LIN_BYTE_W{1'b1}};

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESOLVE = 1'b1
    } state_t;

    localparam logic [5:0] UNCOND_FRAME1 = 6'h25;
    localparam logic [5:0] UNCOND_FRAME2 = 6'h26;

endpackage

// File: rtl/lin_prio_enc.sv
// Lowest-set-bit encoder: reports whether any request bit is set and the index of the lowest one.
module lin_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/evt_trig_collision_resolver.sv
// LIN event-triggered frame responder: publishes pending slave responses, detects
// multi-responder collisions and serves the colliding slaves on master resolution slots.
//
// state      | meaning
// ST_IDLE    | answering event-triggered headers from the pending set
// ST_RESOLVE | serving resolve_mask lowest-index first, one slave per sched_req
module evt_trig_collision_resolver
    import lin_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int BYTE_W     = LIN_BYTE_W,
    parameter int IDX_W      = $clog2(NUM_SLAVES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         evt_req,
    input  logic                         sched_req,
    input  logic [NUM_SLAVES-1:0]        updated,
    input  logic [NUM_SLAVES*BYTE_W-1:0] data_bytes,
    output logic [BYTE_W-1:0]            data_published,
    output logic                         pub_valid,
    output logic                         collision_det,
    output logic                         resolving,
    output logic [IDX_W-1:0]             serve_idx,
    output logic                         evt_busy
);

    state_t                  state;
    logic [NUM_SLAVES-1:0]   pending;
    logic [NUM_SLAVES-1:0]   resolve_mask;
    logic                    drop_pub;

    logic [NUM_SLAVES-1:0]   enc_in;
    logic                    enc_found;
    logic [IDX_W-1:0]        enc_idx;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic [NUM_SLAVES-1:0]   mask_next;
    logic [NUM_SLAVES-1:0]   pend_clr;

    logic [BYTE_W-1:0]       slv_byte [NUM_SLAVES];
    logic [BYTE_W-1:0]       and_acc  [NUM_SLAVES+1];
    logic [NUM_SLAVES:0]     seen;
    logic [NUM_SLAVES:0]     multi;

    // One encoder serves both states: pending while idle, the frozen collision set while resolving.
    assign enc_in = (state == ST_RESOLVE) ? resolve_mask : pending;

    lin_prio_enc #(
        .N  (NUM_SLAVES),
        .IW (IDX_W)
    ) u_prio_enc (
        .req   (enc_in),
        .found (enc_found),
        .idx   (enc_idx)
    );

    assign and_acc[0] = {BYTE_W{1'b1}};
    assign seen[0]    = 1'b0;
    assign multi[0]   = 1'b0;

    // Wired-AND of pending bytes and a saturating 0/1/many count of pending slaves.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
        assign slv_byte[gi]    = data_bytes[gi*BYTE_W +: BYTE_W];
        assign and_acc[gi+1]   = pending[gi] ? (and_acc[gi] & slv_byte[gi]) : and_acc[gi];
        assign seen[gi+1]      = seen[gi] | pending[gi];
        assign multi[gi+1]     = multi[gi] | (seen[gi] & pending[gi]);
        assign sel_onehot[gi]  = (enc_idx == IDX_W'(gi));
    end

    assign mask_next = resolve_mask & ~sel_onehot;

    always_comb begin
        pend_clr = '0;
        if (state == ST_IDLE && evt_req && enc_found) begin
            pend_clr = multi[NUM_SLAVES] ? pending : sel_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            pending        <= '0;
            resolve_mask   <= '0;
            drop_pub       <= 1'b0;
            data_published <= {BYTE_W{1'b1}};
            pub_valid      <= 1'b0;
            collision_det  <= 1'b0;
            resolving      <= 1'b0;
            serve_idx      <= '0;
            evt_busy       <= 1'b0;
        end else begin
            // A fresh update outranks the serve-clear of the same cycle.
            pending       <= (pending & ~pend_clr) | updated;
            pub_valid     <= 1'b0;
            collision_det <= 1'b0;
            evt_busy      <= 1'b0;
            drop_pub      <= 1'b0;
            if (drop_pub) begin
                data_published <= {BYTE_W{1'b1}};
            end
            case (state)
                ST_IDLE: begin
                    if (evt_req) begin
                        if (!enc_found) begin
                            data_published <= {BYTE_W{1'b1}};
                        end else if (!multi[NUM_SLAVES]) begin
                            data_published <= slv_byte[enc_idx];
                            pub_valid      <= 1'b1;
                            serve_idx      <= enc_idx;
                        end else begin
                            data_published <= and_acc[NUM_SLAVES];
                            pub_valid      <= 1'b1;
                            collision_det  <= 1'b1;
                            serve_idx      <= enc_idx;
                            resolve_mask   <= pending;
                            resolving      <= 1'b1;
                            state          <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    evt_busy <= evt_req;
                    if (sched_req && enc_found) begin
                        data_published <= slv_byte[enc_idx];
                        pub_valid      <= 1'b1;
                        serve_idx      <= enc_idx;
                        resolve_mask   <= mask_next;
                        if (mask_next == '0) begin
                            resolving <= 1'b0;
                            drop_pub  <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evt_trig_collision_resolver.sv
// Scoreboard bench for the event-triggered collision resolver: stimulus pushes expected
// responses, a negedge monitor pops and compares whenever the DUT pulses pub_valid or evt_busy.
module tb_evt_trig_collision_resolver;

    localparam int NS = 4;
    localparam int BW = 10;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           evt_req;
    logic           sched_req;
    logic [NS-1:0]  updated;
    logic [NS*BW-1:0] data_bytes;
    logic [BW-1:0]  data_published;
    logic           pub_valid;
    logic           collision_det;
    logic           resolving;
    logic [IW-1:0]  serve_idx;
    logic           evt_busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [BW-1:0] data;
        logic          valid;
        logic          coll;
        logic          res;
        logic [IW-1:0] idx;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];

    evt_trig_collision_resolver #(
        .NUM_SLAVES (NS),
        .BYTE_W     (BW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .evt_req        (evt_req),
        .sched_req      (sched_req),
        .updated        (updated),
        .data_bytes     (data_bytes),
        .data_published (data_published),
        .pub_valid      (pub_valid),
        .collision_det  (collision_det),
        .resolving      (resolving),
        .serve_idx      (serve_idx),
        .evt_busy       (evt_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [BW-1:0] d, input logic v, input logic c,
                        input logic r, input logic [IW-1:0] i, input logic b);
        exp_t e;
        e.data = d; e.valid = v; e.coll = c; e.res = r; e.idx = i; e.busy = b;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs; returns at the negedge where the registered response is visible.
    task automatic pulse(input logic e, input logic s, input logic [NS-1:0] u);
        @(negedge clk);
        evt_req   = e;
        sched_req = s;
        updated   = u;
        @(negedge clk);
        evt_req   = 1'b0;
        sched_req = 1'b0;
        updated   = '0;
    endtask

    task automatic set_byte(input int i, input logic [BW-1:0] v);
        data_bytes[i*BW +: BW] = v;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " data"},      data_published,     10'h3FF);
        chk({tag, " pub_valid"}, BW'(pub_valid),     '0);
        chk({tag, " coll"},      BW'(collision_det), '0);
        chk({tag, " resolving"}, BW'(resolving),     '0);
        chk({tag, " serve_idx"}, BW'(serve_idx),     '0);
        chk({tag, " evt_busy"},  BW'(evt_busy),      '0);
    endtask

    always @(negedge clk) begin
        if (pub_valid === 1'b1 || evt_busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: pub_valid=%b evt_busy=%b data=%h idx=%0d, none expected",
                         pub_valid, evt_busy, data_published, serve_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon data",      data_published,     e.data);
                chk("mon pub_valid", BW'(pub_valid),     BW'(e.valid));
                chk("mon coll",      BW'(collision_det), BW'(e.coll));
                chk("mon resolving", BW'(resolving),     BW'(e.res));
                chk("mon serve_idx", BW'(serve_idx),     BW'(e.idx));
                chk("mon evt_busy",  BW'(evt_busy),      BW'(e.busy));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        evt_req    = 1'b0;
        sched_req  = 1'b0;
        updated    = '0;
        data_bytes = '0;
        set_byte(0, 10'h24A);
        set_byte(1, 10'h24A);
        set_byte(2, 10'h1F3);
        set_byte(3, 10'h2AA);

        // 1: reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // sched_req in IDLE is ignored
        pulse(1'b0, 1'b1, 4'b0000);
        chk("idle sched no pub", BW'(pub_valid), '0);

        // 2: single responder, then empty event
        pulse(1'b0, 1'b0, 4'b0010);
        push(10'h24A, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        pulse(1'b1, 1'b0, 4'b0000);
        set_byte(1, 10'h000);
        pulse(1'b0, 1'b0, 4'b0000);
        chk("held after change", data_published, 10'h24A);
        pulse(1'b1, 1'b0, 4'b0000);
        chk("empty evt pub_valid", BW'(pub_valid), '0);
        chk("empty evt data", data_published, 10'h3FF);

        // 3/4: collision between slaves 0 and 1, update+evt during resolve
        set_byte(1, 10'h34C);
        pulse(1'b0, 1'b0, 4'b0011);
        push(10'h248, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
        pulse(1'b1, 1'b0, 4'b0000);
        pulse(1'b0, 1'b0, 4'b0100);
        push(10'h248, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        pulse(1'b1, 1'b0, 4'b0000);
        push(10'h24A, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        pulse(1'b0, 1'b1, 4'b0000);
        push(10'h34C, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        pulse(1'b0, 1'b1, 4'b0000);
        pulse(1'b0, 1'b0, 4'b0000);
        chk("after resolve data", data_published, 10'h3FF);
        chk("after resolve resolving", BW'(resolving), '0);
        push(10'h1F3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        pulse(1'b1, 1'b0, 4'b0000);

        // 5: update in the same cycle slave 1 is served keeps it pending
        pulse(1'b0, 1'b0, 4'b0010);
        push(10'h34C, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        pulse(1'b1, 1'b0, 4'b0010);
        push(10'h34C, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        pulse(1'b1, 1'b0, 4'b0000);
        pulse(1'b1, 1'b0, 4'b0000);
        chk("drained evt pub_valid", BW'(pub_valid), '0);

        // 6: collision 0/3, evt+sched together in RESOLVE, then reset mid-resolve
        pulse(1'b0, 1'b0, 4'b1001);
        push(10'h20A, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
        pulse(1'b1, 1'b0, 4'b0000);
        push(10'h24A, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
        pulse(1'b1, 1'b1, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("mid reset");
        pulse(1'b0, 1'b1, 4'b0000);
        chk("post reset sched pub_valid", BW'(pub_valid), '0);
        chk("post reset sched resolving", BW'(resolving), '0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", BW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
